operand_shiftreg: RTL and testbench

Parametrised digit-serial operand register for the Montgomery multiplier datapath. It holds one WIDTH-bit operand, loaded either from the A bus or from the fed-back partial result (reg_rji), selected by lock. On start it streams the operand out LSB-first, DIGIT bits per enabled cycle, and signals completion with a one-cycle done pulse. It replaces fixed-width single-load operand registers with a loadable, serially-drained register that carries its own sequencing.

---
 rtl/operand_shiftreg.sv | 122 ++++++++++++
 tb/tb_operand_shiftreg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_shiftreg.sv
// Digit-serial operand register for the Montgomery multiplier datapath.
// Build option: define SHIFTREG_ROTATE_EN to rotate instead of zero-fill.
module operand_shiftreg #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear_n,
    input  logic             lock,
    input  logic             ld,
    input  logic             start,
    input  logic [WIDTH-1:0] reg_rji,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] r_o,
    output logic [DIGIT-1:0] digit_o,
    output logic             digit_vld,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] shift_val;

    assign load_val = lock ? reg_rji : a;

`ifdef SHIFTREG_ROTATE_EN
    // Outgoing digit re-enters at the top so a full pass restores the operand
    assign shift_val = (r_q >> DIGIT) | (r_q << (WIDTH - DIGIT));
`else
    // Vacated MSBs are zero-filled; a full pass leaves the register empty
    assign shift_val = r_q >> DIGIT;
`endif

    // State, operand and step counter; ena=0 freezes everything
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else if (ena) begin
            if (!clear_n) begin
                state_q <= S_IDLE;
                r_q     <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                r_q     <= r_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    // Next-state, load and shift sequencing
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (ld) begin
                    r_d = load_val;
                end
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                r_d   = shift_val;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ld) begin
                    r_d = load_val;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        digit_vld = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_SHIFT: begin
                digit_vld = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign r_o     = r_q;
    assign digit_o = r_q[DIGIT-1:0];

endmodule

// File: tb/tb_operand_shiftreg.sv
// Self-checking bench for operand_shiftreg (WIDTH=8, DIGIT=2).
// Expected digits are queued at stimulus time and popped as they stream out.
module tb_operand_shiftreg;

    localparam int W = 8;
    localparam int D = 2;

`ifdef SHIFTREG_ROTATE_EN
    localparam logic [W-1:0] FINAL_B4 = 8'hB4;
`else
    localparam logic [W-1:0] FINAL_B4 = 8'h00;
`endif

    logic         clk;
    logic         rstb;
    logic         ena;
    logic         clear_n;
    logic         lock;
    logic         ld;
    logic         start;
    logic [W-1:0] reg_rji;
    logic [W-1:0] a;
    logic [W-1:0] r_o;
    logic [D-1:0] digit_o;
    logic         digit_vld;
    logic         busy;
    logic         done;

    int vec;
    int errs;
    logic [D-1:0] exp_q[$];

    operand_shiftreg #(.WIDTH(W), .DIGIT(D)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .clear_n  (clear_n),
        .lock     (lock),
        .ld       (ld),
        .start    (start),
        .reg_rji  (reg_rji),
        .a        (a),
        .r_o      (r_o),
        .digit_o  (digit_o),
        .digit_vld(digit_vld),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; clear_n = 1'b1;
        lock = 1'b0; ld = 1'b0; start = 1'b0;
        reg_rji = '0; a = 8'h3C;
        step();
        step();
        vec++;
        if (r_o !== 8'h00) begin
            errs++; $display("FAIL reset_r_o: got %h want 00", r_o);
        end
        vec++;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        vec++;
        if (done !== 1'b0) begin
            errs++; $display("FAIL reset_done: got %b want 0", done);
        end
        vec++;
        if (digit_vld !== 1'b0) begin
            errs++; $display("FAIL reset_vld: got %b want 0", digit_vld);
        end
        rstb = 1'b1;
        step();
    endtask

    task automatic test_shift_a();
        logic [D-1:0] e;
        int done_at;
        int ndone;
        done_at = -1; ndone = 0;
        lock = 1'b0; a = 8'hB4; reg_rji = 8'h11;
        ld = 1'b1; start = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        step();
        ld = 1'b0; start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (digit_vld === 1'b1) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL a_extra: got %0d want none", digit_o);
                end else begin
                    e = exp_q.pop_front();
                    if (digit_o !== e) begin
                        errs++; $display("FAIL a_digit%0d: got %0d want %0d", c, digit_o, e);
                    end
                end
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            step();
        end
        vec++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL a_left: got %0d want 0", exp_q.size());
            exp_q.delete();
        end
        vec++;
        if (done_at != 4 || ndone != 1) begin
            errs++; $display("FAIL a_done: got at %0d x%0d want at 4 x1", done_at, ndone);
        end
        vec++;
        if (r_o !== FINAL_B4) begin
            errs++; $display("FAIL a_final: got %h want %h", r_o, FINAL_B4);
        end
    endtask

    task automatic test_load_rji();
        logic [D-1:0] e;
        int done_at;
        done_at = -1;
        lock = 1'b1; reg_rji = 8'h5A; a = 8'h00;
        ld = 1'b1;
        step();
        ld = 1'b0;
        vec++;
        if (r_o !== 8'h5A || busy !== 1'b0) begin
            errs++; $display("FAIL rji_load: got %h/%b want 5a/0", r_o, busy);
        end
        start = 1'b1;
        exp_q.push_back(2'd2); exp_q.push_back(2'd2);
        exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (digit_vld === 1'b1) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL rji_extra: got %0d want none", digit_o);
                end else begin
                    e = exp_q.pop_front();
                    if (digit_o !== e) begin
                        errs++; $display("FAIL rji_digit%0d: got %0d want %0d", c, digit_o, e);
                    end
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            step();
        end
        vec++;
        if (exp_q.size() != 0 || done_at != 4) begin
            errs++; $display("FAIL rji_end: got left %0d done %0d want 0/4", exp_q.size(), done_at);
            exp_q.delete();
        end
        lock = 1'b0;
    endtask

    task automatic test_clear();
        logic [D-1:0] e;
        int ndone;
        ndone = 0;
        a = 8'hB4; ld = 1'b1; start = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        step();
        ld = 1'b0; start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vec++;
            if (digit_vld !== 1'b1 || exp_q.size() == 0) begin
                errs++; $display("FAIL clr_vld%0d: got %b want 1", c, digit_vld);
            end else begin
                e = exp_q.pop_front();
                if (digit_o !== e) begin
                    errs++; $display("FAIL clr_digit%0d: got %0d want %0d", c, digit_o, e);
                end
            end
            if (c == 1) clear_n = 1'b0;
            step();
        end
        clear_n = 1'b1;
        vec++;
        if (r_o !== 8'h00 || busy !== 1'b0 || digit_vld !== 1'b0) begin
            errs++; $display("FAIL clr_state: got %h/%b/%b want 00/0/0", r_o, busy, digit_vld);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        vec++;
        if (ndone != 0) begin
            errs++; $display("FAIL clr_nodone: got %0d want 0", ndone);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [D-1:0] e;
        int done_at;
        done_at = -1;
        a = 8'hB4; ld = 1'b1; start = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        step();
        ld = 1'b0; start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2 || c == 3) begin
                vec++;
                if (digit_o !== 2'd1 || digit_vld !== 1'b1) begin
                    errs++; $display("FAIL stall_hold%0d: got %0d/%b want 1/1", c, digit_o, digit_vld);
                end
            end else if (digit_vld === 1'b1) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL stall_extra: got %0d want none", digit_o);
                end else begin
                    e = exp_q.pop_front();
                    if (digit_o !== e) begin
                        errs++; $display("FAIL stall_digit%0d: got %0d want %0d", c, digit_o, e);
                    end
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c == 1) ena = 1'b0;
            if (c == 3) ena = 1'b1;
            step();
        end
        vec++;
        if (exp_q.size() != 0 || done_at != 6) begin
            errs++; $display("FAIL stall_end: got left %0d done %0d want 0/6", exp_q.size(), done_at);
            exp_q.delete();
        end
    endtask

    task automatic test_ld_ignored();
        logic [D-1:0] e;
        int done_at;
        done_at = -1;
        lock = 1'b0; a = 8'hB4; ld = 1'b1; start = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        step();
        ld = 1'b0; start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (digit_vld === 1'b1) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL ldig_extra: got %0d want none", digit_o);
                end else begin
                    e = exp_q.pop_front();
                    if (digit_o !== e) begin
                        errs++; $display("FAIL ldig_digit%0d: got %0d want %0d", c, digit_o, e);
                    end
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c == 1) begin
                a = 8'hFF; ld = 1'b1;
            end
            if (c == 2) ld = 1'b0;
            step();
        end
        vec++;
        if (exp_q.size() != 0 || done_at != 4) begin
            errs++; $display("FAIL ldig_end: got left %0d done %0d want 0/4", exp_q.size(), done_at);
            exp_q.delete();
        end
        vec++;
        if (r_o !== FINAL_B4) begin
            errs++; $display("FAIL ldig_final: got %h want %h", r_o, FINAL_B4);
        end
    endtask

    initial begin
        vec = 0;
        errs = 0;
        test_reset();
        test_shift_a();
        test_load_rji();
        test_clear();
        test_stall();
        test_ld_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
